calc1_ref_model: RTL



---
 rtl/calc1_ref_model_if.sv | 27 ++
 rtl/calc1_ref_model.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/calc1_ref_model_if.sv
`default_nettype none
// ============================================================================
// Module   : calc1_ref_model_if
// Brief    : Four-port calc1 request/response bundle (bit 0 is the MSB).
// Revision : 1.0 - initial release
// ============================================================================
interface calc1_ref_model_if;
    logic [0:3]  req_cmd_in  [1:4];
    logic [0:31] req_data_in [1:4];
    logic [0:31] out_data    [1:4];
    logic [0:1]  out_resp    [1:4];

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_data,
        input  out_resp
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_data,
        output out_resp
    );
endinterface
`default_nettype wire

// File: rtl/calc1_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : calc1_ref_model
// Brief    : Cycle-level reference model of the four-port calc1 calculator.
//            Define CALC1_REF_PROTO_CHECK_EN for dropped-command reporting.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_ref_model #(
    parameter int LATENCY = 3
) (
    input  wire logic        c_clk,
    input  wire logic        reset,
    calc1_ref_model_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_op2  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    localparam logic [3:0] c_cmd_add = 4'd1;
    localparam logic [3:0] c_cmd_sub = 4'd2;
    localparam logic [3:0] c_cmd_shl = 4'd5;
    localparam logic [3:0] c_cmd_shr = 4'd6;

    localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

    logic [1:0]  state_q    [1:4];
    logic [1:0]  state_d    [1:4];
    logic [3:0]  cmd_q      [1:4];
    logic [3:0]  cmd_d      [1:4];
    logic [31:0] op1_q      [1:4];
    logic [31:0] op1_d      [1:4];
    logic [3:0]  cnt_q      [1:4];
    logic [3:0]  cnt_d      [1:4];
    logic [1:0]  res_resp_q [1:4];
    logic [1:0]  res_resp_d [1:4];
    logic [31:0] res_data_q [1:4];
    logic [31:0] res_data_d [1:4];
    logic [1:0]  out_resp_q [1:4];
    logic [1:0]  out_resp_d [1:4];
    logic [31:0] out_data_q [1:4];
    logic [31:0] out_data_d [1:4];

    // Returns {resp, data}; only the low five bits of b steer the shifts.
    function automatic logic [33:0] calc_result(
        input logic [3:0]  cmd,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] sum;
        logic [4:0]  sh;
        sum = {1'b0, a} + {1'b0, b};
        sh  = b[4:0];
        case (cmd)
            c_cmd_add: calc_result = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            c_cmd_sub: calc_result = (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
            c_cmd_shl: calc_result = {2'd1, a << sh};
            c_cmd_shr: calc_result = {2'd1, a >> sh};
            default:   calc_result = {2'd2, 32'd0};
        endcase
    endfunction

    always_comb begin
        for (int p = 1; p <= 4; p++) begin
            state_d[p]    = state_q[p];
            cmd_d[p]      = cmd_q[p];
            op1_d[p]      = op1_q[p];
            cnt_d[p]      = cnt_q[p];
            res_resp_d[p] = res_resp_q[p];
            res_data_d[p] = res_data_q[p];
            out_resp_d[p] = 2'd0;
            out_data_d[p] = 32'd0;
            case (state_q[p])
                c_st_idle: begin
                    if (bus.req_cmd_in[p] != 4'd0) begin
                        cmd_d[p]   = bus.req_cmd_in[p];
                        op1_d[p]   = bus.req_data_in[p];
                        state_d[p] = c_st_op2;
                    end
                end
                c_st_op2: begin
                    {res_resp_d[p], res_data_d[p]} =
                        calc_result(cmd_q[p], op1_q[p], bus.req_data_in[p]);
                    cnt_d[p]   = c_lat_load;
                    state_d[p] = c_st_wait;
                end
                c_st_wait: begin
                    if (cnt_q[p] == 4'd0) begin
                        out_resp_d[p] = res_resp_q[p];
                        out_data_d[p] = res_data_q[p];
                        state_d[p]    = c_st_idle;
                    end else begin
                        cnt_d[p] = cnt_q[p] - 4'd1;
                    end
                end
                default: state_d[p] = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 1; p <= 4; p++) begin
            if (reset) begin
                state_q[p]    <= c_st_idle;
                cmd_q[p]      <= 4'd0;
                op1_q[p]      <= 32'd0;
                cnt_q[p]      <= 4'd0;
                res_resp_q[p] <= 2'd0;
                res_data_q[p] <= 32'd0;
                out_resp_q[p] <= 2'd0;
                out_data_q[p] <= 32'd0;
            end else begin
                state_q[p]    <= state_d[p];
                cmd_q[p]      <= cmd_d[p];
                op1_q[p]      <= op1_d[p];
                cnt_q[p]      <= cnt_d[p];
                res_resp_q[p] <= res_resp_d[p];
                res_data_q[p] <= res_data_d[p];
                out_resp_q[p] <= out_resp_d[p];
                out_data_q[p] <= out_data_d[p];
            end
        end
    end

    for (genvar gp = 1; gp <= 4; gp++) begin : g_out
        assign bus.out_resp[gp] = out_resp_q[gp];
        assign bus.out_data[gp] = out_data_q[gp];
    end

`ifdef CALC1_REF_PROTO_CHECK_EN
    // Any nonzero command while a port is not idle is discarded.
    logic [15:0] drop_count   [1:4];
    logic [15:0] drop_count_d [1:4];
    logic        drop_event   [1:4];

    always_comb begin
        for (int p = 1; p <= 4; p++) begin
            drop_event[p]   = (state_q[p] != c_st_idle) && (bus.req_cmd_in[p] != 4'd0);
            drop_count_d[p] = drop_count[p];
            if (drop_event[p] && (drop_count[p] != 16'hFFFF)) begin
                drop_count_d[p] = drop_count[p] + 16'd1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 1; p <= 4; p++) begin
            if (reset) begin
                drop_count[p] <= 16'd0;
            end else begin
                drop_count[p] <= drop_count_d[p];
                if (drop_event[p]) begin
                    $display("%0t PROTOCOL: port %0d cmd %0d dropped (busy)",
                             $time, p, bus.req_cmd_in[p]);
                end
            end
        end
    end
`else
`endif

endmodule
`default_nettype wire
